// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer driven by decoded CSR fields.
// Produces start bit, DATA_W data bits LSB first, optional parity and one or
// two stop bits. A one-entry holding register queues the next byte so that
// back-to-back frames go out with no idle gap.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   baud_div         cycles per bit (0 behaves as 1), latched per frame
//   tx_en            transmit enable; dropping it aborts the current frame
//   parity_en/odd    parity enable and sense, latched per frame
//   stop2            two stop bits when set, latched per frame
//   send_valid/data  byte write pulse and byte
//   ovr_clr          clears the sticky overrun flag
//   tx               serial line (idle high)
//   tx_busy          frame in flight or holding register full
//   tx_done          one-cycle pulse after the final stop period
//   tx_overrun       sticky: a write was dropped
//   hold_full        holding register occupied
module uart_tx_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned BAUD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [BAUD_W-1:0] baud_div,
  input  logic              tx_en,
  input  logic              parity_en,
  input  logic              parity_odd,
  input  logic              stop2,
  input  logic              send_valid,
  input  logic [DATA_W-1:0] send_data,
  input  logic              ovr_clr,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done,
  output logic              tx_overrun,
  output logic              hold_full
);

  localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP1  = 3'd4,
    STOP2  = 3'd5
  } state_t;

  state_t            state, state_nx;
  logic [BAUD_W-1:0] cnt, cnt_nx;
  logic [BAUD_W-1:0] div_lat, div_nx;
  logic [BAUD_W-1:0] div_eff;
  logic [BIT_W-1:0]  bit_cnt, bit_nx;
  logic [DATA_W-1:0] shreg, shreg_nx;
  logic [DATA_W-1:0] hold, hold_nx;
  logic [DATA_W-1:0] load_data;
  logic              par_en_lat, par_en_nx;
  logic              par_odd_lat, par_odd_nx;
  logic              stop2_lat, stop2_nx;
  logic              hold_full_nx, ovr_nx, tx_done_nx, tx_nx, busy_nx;
  logic              bit_end, frame_end, load;

  // Next-state, datapath and output computation.
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    div_nx       = div_lat;
    bit_nx       = bit_cnt;
    shreg_nx     = shreg;
    hold_nx      = hold;
    par_en_nx    = par_en_lat;
    par_odd_nx   = par_odd_lat;
    stop2_nx     = stop2_lat;
    hold_full_nx = hold_full;
    ovr_nx       = tx_overrun & ~ovr_clr;
    tx_done_nx   = 1'b0;
    load         = 1'b0;
    load_data    = '0;
    frame_end    = 1'b0;
    div_eff      = (baud_div == '0) ? BAUD_W'(1) : baud_div;
    bit_end      = (cnt == '0);

    if (!tx_en) begin
      // Abort: drop the frame and anything queued, keep the overrun flag.
      state_nx     = IDLE;
      hold_full_nx = 1'b0;
      cnt_nx       = '0;
      bit_nx       = '0;
    end else begin
      if (state == IDLE) begin
        if (send_valid) begin
          load      = 1'b1;
          load_data = send_data;
        end
      end else if (!bit_end) begin
        cnt_nx = cnt - BAUD_W'(1);
      end else begin
        cnt_nx = div_lat - BAUD_W'(1);
        case (state)
          START: begin
            state_nx = DATA;
            bit_nx   = '0;
          end
          DATA: begin
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              state_nx = par_en_lat ? PARITY : STOP1;
            end else begin
              bit_nx = bit_cnt + BIT_W'(1);
            end
          end
          PARITY: state_nx = STOP1;
          STOP1: begin
            if (stop2_lat) begin
              state_nx = STOP2;
            end else begin
              frame_end = 1'b1;
            end
          end
          STOP2:   frame_end = 1'b1;
          default: state_nx = IDLE;
        endcase
      end

      // End of frame: chain straight into the held byte (or a byte written
      // this very cycle) so the line never idles between frames.
      if (frame_end) begin
        tx_done_nx = 1'b1;
        state_nx   = IDLE;
        cnt_nx     = '0;
        bit_nx     = '0;
        if (hold_full) begin
          load         = 1'b1;
          load_data    = hold;
          hold_full_nx = 1'b0;
        end else if (send_valid) begin
          load      = 1'b1;
          load_data = send_data;
        end
      end

      // Holding register write; a write into a full register is dropped,
      // except on the cycle the held byte moves out.
      if (send_valid && (state != IDLE) && (hold_full || !frame_end)) begin
        if (hold_full && !frame_end) begin
          ovr_nx = 1'b1;
        end else begin
          hold_nx      = send_data;
          hold_full_nx = 1'b1;
        end
      end

      // Frame start: latch byte and per-frame configuration.
      if (load) begin
        state_nx   = START;
        shreg_nx   = load_data;
        div_nx     = div_eff;
        par_en_nx  = parity_en;
        par_odd_nx = parity_odd;
        stop2_nx   = stop2;
        cnt_nx     = div_eff - BAUD_W'(1);
        bit_nx     = '0;
      end
    end

    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[bit_nx];
      PARITY:  tx_nx = (^shreg_nx) ^ par_odd_nx;
      default: tx_nx = 1'b1;
    endcase
    busy_nx = (state_nx != IDLE) | hold_full_nx;
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      div_lat     <= BAUD_W'(1);
      bit_cnt     <= '0;
      shreg       <= '0;
      hold        <= '0;
      par_en_lat  <= 1'b0;
      par_odd_lat <= 1'b0;
      stop2_lat   <= 1'b0;
      tx          <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_overrun  <= 1'b0;
      hold_full   <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      div_lat     <= div_nx;
      bit_cnt     <= bit_nx;
      shreg       <= shreg_nx;
      hold        <= hold_nx;
      par_en_lat  <= par_en_nx;
      par_odd_lat <= par_odd_nx;
      stop2_lat   <= stop2_nx;
      tx          <= tx_nx;
      tx_busy     <= busy_nx;
      tx_done     <= tx_done_nx;
      tx_overrun  <= ovr_nx;
      hold_full   <= hold_full_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a frame-level model (queue of
// expected line levels per cycle) is compared against the DUT every cycle,
// and directed tests pin frame lengths, bit values and flag behaviour.
module tb_uart_tx_ctrl;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BAUD_W = 16;
  localparam int HIST = 4096;

  logic              clk;
  logic              rst_n;
  logic [BAUD_W-1:0] baud_div;
  logic              tx_en, parity_en, parity_odd, stop2;
  logic              send_valid, ovr_clr;
  logic [DATA_W-1:0] send_data;
  logic              tx, tx_busy, tx_done, tx_overrun, hold_full;

  uart_tx_ctrl #(.DATA_W(DATA_W), .BAUD_W(BAUD_W)) dut (
    .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .tx_en(tx_en),
    .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .send_valid(send_valid), .send_data(send_data), .ovr_clr(ovr_clr),
    .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done),
    .tx_overrun(tx_overrun), .hold_full(hold_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: queue of line levels still to be sent, one entry per clock.
  bit              m_q[$];
  bit              m_hold_v, m_done, m_ovr;
  logic [DATA_W-1:0] m_hold;
  logic            tx_hist[0:HIST-1];
  int              done_q[$];
  int              send_q[$];

  task automatic build(input logic [DATA_W-1:0] b);
    int n;
    bit bits[$];
    n = (baud_div == 0) ? 1 : int'(baud_div);
    bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(b[i]);
    if (parity_en) bits.push_back((^b) ^ parity_odd);
    bits.push_back(1'b1);
    if (stop2) bits.push_back(1'b1);
    foreach (bits[i]) for (int k = 0; k < n; k++) m_q.push_back(bits[i]);
  endtask

  // Model update on each edge, then compare just after it.
  always begin
    @(posedge clk);
    cyc++;
    m_done = 1'b0;
    if (!rst_n) begin
      m_q.delete();
      m_hold_v = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      if (ovr_clr) m_ovr = 1'b0;
      if (!tx_en) begin
        m_q.delete();
        m_hold_v = 1'b0;
      end else if (m_q.size() == 0) begin
        if (send_valid) begin
          build(send_data);
          send_q.push_back(cyc);
        end
      end else begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) begin
          m_done = 1'b1;
          if (m_hold_v) begin
            build(m_hold);
            m_hold_v = 1'b0;
            if (send_valid) begin
              m_hold   = send_data;
              m_hold_v = 1'b1;
            end
          end else if (send_valid) begin
            build(send_data);
          end
        end else if (send_valid) begin
          if (m_hold_v) m_ovr = 1'b1;
          else begin
            m_hold   = send_data;
            m_hold_v = 1'b1;
          end
        end
      end
    end
    #1;
    chk("cyc_tx",      32'(tx),         32'((m_q.size() == 0) ? 1'b1 : m_q[0]));
    chk("cyc_done",    32'(tx_done),    32'(m_done));
    chk("cyc_busy",    32'(tx_busy),    32'((m_q.size() != 0) || m_hold_v));
    chk("cyc_hold",    32'(hold_full),  32'(m_hold_v));
    chk("cyc_overrun", 32'(tx_overrun), 32'(m_ovr));
    if (tx_done === 1'b1) done_q.push_back(cyc);
    if (cyc < HIST) tx_hist[cyc] = tx;
  end

  function automatic int dq(input int i);
    return (i < done_q.size()) ? done_q[i] : -1000;
  endfunction

  function automatic int sq(input int i);
    return (i < send_q.size()) ? send_q[i] : -1000;
  endfunction

  function automatic logic hist(input int c);
    return (c >= 0 && c < HIST) ? tx_hist[c] : 1'bx;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [DATA_W-1:0] b);
    send_valid = 1'b1;
    send_data  = b;
    @(negedge clk);
    send_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max);
    int k = 0;
    while (tx_busy !== 1'b0 && k < max) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(tx_busy), 32'(0));
    tick(2);
  endtask

  task automatic new_test();
    done_q.delete();
    send_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int s;

  initial begin
    rst_n = 1'b0; baud_div = 16'd4; tx_en = 1'b0; parity_en = 1'b0;
    parity_odd = 1'b0; stop2 = 1'b0; send_valid = 1'b0; send_data = '0;
    ovr_clr = 1'b0;
    tick(3);
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(tx_busy), 32'(0));
    chk("rst_overrun", 32'(tx_overrun), 32'(0));
    rst_n = 1'b1;
    tx_en = 1'b1;
    tick(2);

    // 8N1 at 4 cycles/bit, 0xA5.
    new_test();
    send(8'hA5);
    wait_idle("A_idle", 200);
    s = sq(0);
    chk("A_len", 32'(dq(0) - s), 32'd40);
    chk("A_start0", 32'(hist(s)), 32'(0));
    chk("A_start3", 32'(hist(s + 3)), 32'(0));
    chk("A_bit0", 32'(hist(s + 4)), 32'(1));
    chk("A_bit1", 32'(hist(s + 8)), 32'(0));
    chk("A_bit5", 32'(hist(s + 24)), 32'(1));
    chk("A_bit7", 32'(hist(s + 32)), 32'(1));
    chk("A_stop", 32'(hist(s + 39)), 32'(1));

    // Even parity, two stop bits, 2 cycles/bit, 0x07.
    new_test();
    baud_div = 16'd2; parity_en = 1'b1; parity_odd = 1'b0; stop2 = 1'b1;
    send(8'h07);
    wait_idle("B_idle", 200);
    s = sq(0);
    chk("B_len", 32'(dq(0) - s), 32'd24);
    chk("B_bit2", 32'(hist(s + 6)), 32'(1));
    chk("B_bit3", 32'(hist(s + 8)), 32'(0));
    chk("B_parity", 32'(hist(s + 18)), 32'(1));
    chk("B_stop1", 32'(hist(s + 20)), 32'(1));
    chk("B_stop2", 32'(hist(s + 22)), 32'(1));
    parity_en = 1'b0; stop2 = 1'b0;

    // Back-to-back frames through the holding register.
    new_test();
    baud_div = 16'd3;
    send(8'h11);
    tick(5);
    send(8'h22);
    chk("C_hold", 32'(hold_full), 32'(1));
    wait_idle("C_idle", 300);
    chk("C_ndone", 32'(done_q.size()), 32'd2);
    chk("C_len", 32'(dq(0) - sq(0)), 32'd30);
    chk("C_gap", 32'(dq(1) - dq(0)), 32'd30);
    chk("C_nogap", 32'(hist(dq(0))), 32'(0));

    // Overrun set, sticky, cleared, and set-wins-over-clear.
    new_test();
    baud_div = 16'd2;
    send(8'h01);
    tick(2);
    send(8'h02);
    tick(2);
    send(8'h03);
    chk("D_ovr_set", 32'(tx_overrun), 32'(1));
    tick(3);
    chk("D_ovr_sticky", 32'(tx_overrun), 32'(1));
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    chk("D_ovr_clr", 32'(tx_overrun), 32'(0));
    ovr_clr = 1'b1;
    send(8'h04);
    ovr_clr = 1'b0;
    chk("D_ovr_setwins", 32'(tx_overrun), 32'(1));
    wait_idle("D_idle", 300);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;

    // Abort during data bit 3 with a byte queued.
    new_test();
    baud_div = 16'd4;
    send(8'h5A);
    tick(1);
    send(8'hA5);
    tick(15);
    tx_en = 1'b0;
    @(negedge clk);
    chk("E_tx", 32'(tx), 32'(1));
    chk("E_hold", 32'(hold_full), 32'(0));
    chk("E_busy", 32'(tx_busy), 32'(0));
    tick(60);
    chk("E_nodone", 32'(done_q.size()), 32'd0);
    send(8'h33);
    tick(3);
    chk("E_dis_busy", 32'(tx_busy), 32'(0));
    chk("E_dis_tx", 32'(tx), 32'(1));
    chk("E_dis_ovr", 32'(tx_overrun), 32'(0));
    tx_en = 1'b1;
    tick(2);

    // Divisor 0 behaves as 1.
    new_test();
    baud_div = 16'd0;
    send(8'h3C);
    wait_idle("F_idle", 100);
    chk("F_len", 32'(dq(0) - sq(0)), 32'd10);

    // Divisor change mid-frame applies to the next frame only.
    new_test();
    baud_div = 16'd4;
    send(8'h81);
    tick(3);
    baud_div = 16'd8;
    send(8'h42);
    wait_idle("G_idle", 500);
    chk("G_len1", 32'(dq(0) - sq(0)), 32'd40);
    chk("G_len2", 32'(dq(1) - dq(0)), 32'd80);

    // Reset during the stop bit with overrun and hold set.
    new_test();
    baud_div = 16'd4;
    send(8'h0F);
    tick(1);
    send(8'h10);
    tick(1);
    send(8'h20);
    chk("H_ovr", 32'(tx_overrun), 32'(1));
    tick(33);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("H_tx", 32'(tx), 32'(1));
    chk("H_busy", 32'(tx_busy), 32'(0));
    chk("H_ovr_rst", 32'(tx_overrun), 32'(0));
    chk("H_hold", 32'(hold_full), 32'(0));
    tick(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
